// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: applies mixer mode changes on vsync boundaries behind a blanked picture.
// Optional vsync watchdog enabled by defining VIDEO_MODE_CTRL_TIMEOUT_EN.
module video_mode_ctrl #(
    parameter int BLANK_FRAMES   = 2,
    parameter int SETTLE_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic cfg_valid,
    output logic cfg_ready,
    input  logic cfg_sd_disable,
    input  logic cfg_ypbpr,
    input  logic cfg_ypbpr_full,
    input  logic vsync_i,
    input  logic vsync_p,
    output logic scandoubler_disable,
    output logic ypbpr,
    output logic ypbpr_full,
    output logic blank,
    output logic mode_changed
);
    localparam int CMAX = (BLANK_FRAMES > SETTLE_FRAMES) ? BLANK_FRAMES : SETTLE_FRAMES;
    localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, FADE, APPLY, SETTLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    cur_q, cur_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    req;
    logic          vs_dly_q, vs_dly_d;
    logic          blank_q, blank_d;
    logic          ready_q, ready_d;
    logic          mc_q, mc_d;
    logic          vs_src, vs_edge, tick, accept, waiting, last;

    assign req     = {cfg_sd_disable, cfg_ypbpr, cfg_ypbpr_full};
    assign vs_src  = cur_q[2] ? vsync_i : vsync_p;
    assign vs_edge = vs_src & ~vs_dly_q;
    assign accept  = cfg_valid & ready_q;
    assign waiting = (state_q == FADE) || (state_q == SETTLE);
    assign last    = (cnt_q == '0) || (tick && cnt_q == CW'(1));

`ifdef VIDEO_MODE_CTRL_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_hit;

    // A silent sync source still advances the frame count once per timeout.
    assign wd_hit = waiting && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign tick   = vs_edge | wd_hit;

    always_comb begin
        wd_d = wd_q + 1'b1;
        if (!waiting || tick || state_d != state_q)
            wd_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`else
    assign tick = vs_edge;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        vs_dly_d = vs_src;
        if (waiting && tick && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_d = req;
                    cnt_d  = CW'(BLANK_FRAMES);
                    if (req != cur_q)
                        state_d = (BLANK_FRAMES == 0) ? APPLY : FADE;
                end
            end
            FADE: begin
                if (last)
                    state_d = APPLY;
            end
            APPLY: begin
                cur_d = pend_q;
                // Preload the new source so switching cannot fake an edge.
                vs_dly_d = pend_q[2] ? vsync_i : vsync_p;
                cnt_d    = CW'(SETTLE_FRAMES);
                state_d  = (SETTLE_FRAMES == 0) ? IDLE : SETTLE;
            end
            SETTLE: begin
                if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        blank_d = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        mc_d    = (state_d == APPLY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SETTLE;
            cnt_q    <= CW'(SETTLE_FRAMES);
            cur_q    <= '0;
            pend_q   <= '0;
            vs_dly_q <= 1'b0;
            blank_q  <= 1'b1;
            ready_q  <= 1'b0;
            mc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            vs_dly_q <= vs_dly_d;
            blank_q  <= blank_d;
            ready_q  <= ready_d;
            mc_q     <= mc_d;
        end
    end

    assign scandoubler_disable = cur_q[2];
    assign ypbpr               = cur_q[1];
    assign ypbpr_full          = cur_q[0];
    assign blank               = blank_q;
    assign cfg_ready           = ready_q;
    assign mode_changed        = mc_q;
endmodule
